// File: rtl/fp16_div.sv
// Iterative half-precision divider: restoring division producing one quotient bit per clock,
// with valid/ready handshakes on both the operand and the result side.
module fp16_div #(
   parameter int EW   = 5,
   parameter int MW   = 10,
   parameter int BIAS = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [EW+MW:0]   num,
   input  logic [EW+MW:0]   den,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [EW+MW:0]   quo,
   output logic [1:0]       flags
);

   localparam int W  = 1 + EW + MW;
   localparam int CW = $clog2(MW + 3);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state_q, state_d;
   logic [MW+2:0]   rem_q, rem_d;
   logic [MW:0]     dvs_q, dvs_d;
   logic [MW:0]     quot_q, quot_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            sign_q, sign_d;
   logic [EW-1:0]   ea_q, ea_d, eb_q, eb_d;
   logic [W-1:0]    quo_q, quo_d;
   logic [1:0]      flags_q, flags_d;

   logic            geq;
   logic [MW+1:0]   diff;
   logic [MW+1:0]   qNext;
   logic            adj;
   logic [MW-1:0]   fracRes;
   logic [EW+1:0]   eRes;
   logic            rangeBit;
   logic            signIn;

   // One restoring step plus the normalisation of the finished quotient; the result
   // path is only consumed on the final CALC edge, when qNext holds every quotient bit.
   always_comb begin
      geq      = rem_q >= {2'b00, dvs_q};
      diff     = rem_q[MW+1:0] - {1'b0, dvs_q};
      qNext    = {quot_q, geq};
      adj      = ~qNext[MW+1];
      fracRes  = qNext[MW+1] ? qNext[MW:1] : qNext[MW-1:0];
      eRes     = {2'b00, ea_q} - {2'b00, eb_q} + (EW+2)'(BIAS) - (EW+2)'(adj);
      rangeBit = eRes[EW+1] | eRes[EW];
      signIn   = num[W-1] ^ den[W-1];
   end

   assign in_ready  = (state_q == IDLE) & ~rst;
   assign out_valid = (state_q == DONE);
   assign quo       = quo_q;
   assign flags     = flags_q;

   // Next-state logic; zero magnitudes bypass the iteration entirely.
   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dvs_d   = dvs_q;
      quot_d  = quot_q;
      cnt_d   = cnt_q;
      sign_d  = sign_q;
      ea_d    = ea_q;
      eb_d    = eb_q;
      quo_d   = quo_q;
      flags_d = flags_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready) begin
               sign_d = signIn;
               ea_d   = num[MW+EW-1:MW];
               eb_d   = den[MW+EW-1:MW];
               rem_d  = {2'b01, num[MW-1:0]};
               dvs_d  = {1'b1, den[MW-1:0]};
               quot_d = '0;
               cnt_d  = CW'(MW + 2);
               if (den[W-2:0] == '0) begin
                  quo_d   = {signIn, {EW{1'b1}}, {MW{1'b0}}};
                  flags_d = 2'b10;
                  state_d = DONE;
               end else if (num[W-2:0] == '0) begin
                  quo_d   = {signIn, {(EW+MW){1'b0}}};
                  flags_d = 2'b00;
                  state_d = DONE;
               end else begin
                  state_d = CALC;
               end
            end
         end
         CALC: begin
            quot_d = qNext[MW:0];
            rem_d  = {(geq ? diff : rem_q[MW+1:0]), 1'b0};
            cnt_d  = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               quo_d   = {sign_q, eRes[EW-1:0], fracRes};
               flags_d = {1'b0, rangeBit};
               state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         dvs_q   <= '0;
         quot_q  <= '0;
         cnt_q   <= '0;
         sign_q  <= 1'b0;
         ea_q    <= '0;
         eb_q    <= '0;
         quo_q   <= '0;
         flags_q <= '0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dvs_q   <= dvs_d;
         quot_q  <= quot_d;
         cnt_q   <= cnt_d;
         sign_q  <= sign_d;
         ea_q    <= ea_d;
         eb_q    <= eb_d;
         quo_q   <= quo_d;
         flags_q <= flags_d;
      end
   end

endmodule

// File: tb/tb_fp16_div.sv
// Testbench for fp16_div: directed corner cases and handshake checks, then randomized
// operand pairs compared against an arithmetic reference model of the number format.
module tb_fp16_div;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] num;
   logic [15:0] den;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] quo;
   logic [1:0]  flags;

   int testCount = 0;
   int failCount = 0;

   always #5 clk = ~clk;

   fp16_div dut (
      .clk(clk),
      .rst(rst),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .num(num),
      .den(den),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .quo(quo),
      .flags(flags)
   );

   // Reference: quotient from plain integer division of the 11-bit significands.
   function automatic logic [17:0] refDiv(input logic [15:0] a, input logic [15:0] b);
      logic sign;
      int   ma, mb, q, frac, adj, e;
      logic rng;
      sign = a[15] ^ b[15];
      if (b[14:0] == 15'd0) return {2'b10, sign, 5'h1f, 10'h000};
      if (a[14:0] == 15'd0) return {2'b00, sign, 15'h0000};
      ma = 1024 + int'(a[9:0]);
      mb = 1024 + int'(b[9:0]);
      q  = (ma * 2048) / mb;
      if (q >= 2048) begin
         frac = (q / 2) % 1024;
         adj  = 0;
      end else begin
         frac = q % 1024;
         adj  = 1;
      end
      e   = int'(a[14:10]) - int'(b[14:10]) + 15 - adj;
      rng = (e < 0) || (e > 31);
      return {1'b0, rng, sign, 5'(e & 31), 10'(frac)};
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Called at a falling edge; returns at the falling edge right after the accept edge.
   task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b);
      int guard = 0;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) checkOutput("accept_timeout", 32'(in_ready), 32'd1);
      num      = a;
      den      = b;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic waitResult(input logic [15:0] a, input logic [15:0] b, input string tag);
      logic [17:0] want;
      int lat = 0;
      int expLat;
      want   = refDiv(a, b);
      expLat = (a[14:0] == 15'd0 || b[14:0] == 15'd0) ? 1 : 12;
      do begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end while (!out_valid && lat < 40);
      checkOutput({tag, "_lat"}, 32'(lat), 32'(expLat));
      checkOutput({tag, "_quo"}, 32'(quo), 32'(want[15:0]));
      checkOutput({tag, "_flags"}, 32'(flags), 32'(want[17:16]));
   endtask

   task automatic popResult(input string tag);
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput({tag, "_pop"}, 32'(out_valid), 32'd0);
   endtask

   logic [15:0] dirA [6] = '{16'h4000, 16'h3C00, 16'hC500, 16'h3C00, 16'h8000, 16'h7800};
   logic [15:0] dirB [6] = '{16'h3C00, 16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h0400};

   initial begin
      logic [15:0] ra, rb;
      logic        sawValid;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      num       = 16'h0;
      den       = 16'h0;
      #12;
      checkOutput("rst_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_quo", 32'(quo), 32'd0);
      checkOutput("rst_flags", 32'(flags), 32'd0);
      checkOutput("rst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("idle_ready", 32'(in_ready), 32'd1);
      @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         applyStimulus(dirA[i], dirB[i]);
         waitResult(dirA[i], dirB[i], $sformatf("dir%0d", i));
         popResult("dir");
      end

      // Result held in DONE while a competing operand pair is presented.
      applyStimulus(16'h4000, 16'h3C00);
      waitResult(16'h4000, 16'h3C00, "hold");
      num      = 16'h3C00;
      den      = 16'h4200;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checkOutput("hold_quo", 32'(quo), 32'h4000);
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_ready", 32'(in_ready), 32'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      out_ready = 1'b0;
      checkOutput("queued_valid", 32'(out_valid), 32'd0);
      checkOutput("queued_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      waitResult(16'h3C00, 16'h4200, "queued");
      popResult("queued");

      // Reset in the middle of an iteration drops the operation.
      applyStimulus(16'h4000, 16'h3C00);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      checkOutput("midrst_valid", 32'(out_valid), 32'd0);
      checkOutput("midrst_quo", 32'(quo), 32'd0);
      checkOutput("midrst_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      sawValid = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (out_valid) sawValid = 1'b1;
      end
      checkOutput("midrst_novalid", 32'(sawValid), 32'd0);
      applyStimulus(16'hC500, 16'h4000);
      waitResult(16'hC500, 16'h4000, "afterrst");
      popResult("afterrst");

      for (int i = 0; i < 40; i++) begin
         ra = 16'($urandom);
         rb = 16'($urandom);
         if ($urandom_range(0, 9) == 0) rb[14:0] = 15'd0;
         if ($urandom_range(0, 9) == 0) ra[14:0] = 15'd0;
         applyStimulus(ra, rb);
         waitResult(ra, rb, $sformatf("rnd%0d", i));
         repeat ($urandom_range(0, 3)) @(negedge clk);
         popResult("rnd");
      end

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule
